// File: rtl/tuner_phy_pkg.sv
// Shared types and default sizing for the tuner control path.
package tuner_phy_pkg;

  localparam int TUNER_DAC_W          = 8;
  localparam int TUNER_ADC_W          = 8;
  localparam int TUNER_NUM_TARGET     = 8;
  localparam int TUNER_MAX_RETRY      = 3;
  localparam int TUNER_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_TRIG = 3'd1,
    S_WAIT = 3'd2,
    SELECT = 3'd3,
    L_TRIG = 3'd4,
    LOCKED = 3'd5,
    RESUME = 3'd6,
    ERR    = 3'd7
  } tuner_ctrl_state_e;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    NO_PEAK = 2'd1,
    TIMEOUT = 2'd2,
    RETRY   = 2'd3
  } tuner_ctrl_err_e;

endpackage

// File: rtl/tuner_ctrl_if.sv
// Handshake bundles between tuner_ctrl and the peak-search / lock engines.
interface tuner_search_if #(
  parameter int DAC_WIDTH  = tuner_phy_pkg::TUNER_DAC_W,
  parameter int ADC_WIDTH  = tuner_phy_pkg::TUNER_ADC_W,
  parameter int NUM_TARGET = tuner_phy_pkg::TUNER_NUM_TARGET,
  localparam int CNT_W     = $clog2(NUM_TARGET + 1)
) ();
  logic                 trig_val;
  logic                 trig_rdy;
  logic                 peaks_val;
  logic                 peaks_rdy;
  logic [DAC_WIDTH-1:0] ring_tune_peaks [NUM_TARGET];
  logic [ADC_WIDTH-1:0] pwr_peaks       [NUM_TARGET];
  logic [CNT_W-1:0]     peaks_cnt;

  modport consumer (
    output trig_val, peaks_rdy,
    input  trig_rdy, peaks_val, ring_tune_peaks, pwr_peaks, peaks_cnt
  );
  modport producer (
    input  trig_val, peaks_rdy,
    output trig_rdy, peaks_val, ring_tune_peaks, pwr_peaks, peaks_cnt
  );
endinterface

interface tuner_lock_if ();
  logic trig_val;
  logic trig_rdy;
  logic intr_val;
  logic intr_rdy;
  logic resume_val;
  logic resume_rdy;

  modport consumer (
    output trig_val, intr_rdy, resume_val,
    input  trig_rdy, intr_val, resume_rdy
  );
  modport producer (
    input  trig_val, intr_rdy, resume_val,
    output trig_rdy, intr_val, resume_rdy
  );
endinterface

// File: rtl/tuner_ctrl_peak_sel.sv
// Combinational peak picker: clamped index (mode 0) or first maximum-power slot (mode 1).
module tuner_ctrl_peak_sel
  import tuner_phy_pkg::*;
#(
  parameter int ADC_WIDTH  = TUNER_ADC_W,
  parameter int NUM_TARGET = TUNER_NUM_TARGET,
  localparam int IDX_W     = $clog2(NUM_TARGET),
  localparam int CNT_W     = $clog2(NUM_TARGET + 1)
) (
  input  logic                 i_sel_mode,
  input  logic [IDX_W-1:0]     i_target_idx,
  input  logic [CNT_W-1:0]     i_cnt,
  input  logic [ADC_WIDTH-1:0] i_pwr [NUM_TARGET],
  output logic [IDX_W-1:0]     o_idx
);

  logic [CNT_W-1:0]     w_last;
  logic [IDX_W-1:0]     w_clamp_idx;
  logic [IDX_W-1:0]     w_max_idx;
  logic [ADC_WIDTH-1:0] w_max_pwr;

  always_comb begin
    w_last = i_cnt - CNT_W'(1);
    if (CNT_W'(i_target_idx) < i_cnt) begin
      w_clamp_idx = i_target_idx;
    end else begin
      w_clamp_idx = w_last[IDX_W-1:0];
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    w_max_idx = '0;
    w_max_pwr = i_pwr[0];
    for (int i = 1; i < NUM_TARGET; i++) begin
      if ((CNT_W'(i) < i_cnt) && (i_pwr[i] > w_max_pwr)) begin
        w_max_pwr = i_pwr[i];
        w_max_idx = IDX_W'(i);
      end
    end
  end

  assign o_idx = i_sel_mode ? w_max_idx : w_clamp_idx;

endmodule

// File: rtl/tuner_ctrl.sv
// Search-then-lock sequencer: IDLE wait start | S_TRIG search trigger | S_WAIT await peaks | SELECT pick
// | L_TRIG lock trigger | LOCKED tracking | RESUME re-lock after interrupt | ERR fault held until i_stop.
module tuner_ctrl
  import tuner_phy_pkg::*;
#(
  parameter int DAC_WIDTH      = TUNER_DAC_W,
  parameter int ADC_WIDTH      = TUNER_ADC_W,
  parameter int NUM_TARGET     = TUNER_NUM_TARGET,
  parameter int MAX_RETRY      = TUNER_MAX_RETRY,
  parameter int TIMEOUT_CYCLES = TUNER_TIMEOUT_CYCLES,
  localparam int IDX_W         = $clog2(NUM_TARGET)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic                    i_cfg_sel_mode,
  input  logic [IDX_W-1:0]        i_cfg_target_idx,
  tuner_search_if.consumer        search_if,
  tuner_lock_if.consumer          lock_if,
  output logic [ADC_WIDTH-1:0]    o_cfg_pwr_peak,
  output logic [DAC_WIDTH-1:0]    o_cfg_ring_tune_peak,
  output logic [IDX_W-1:0]        o_sel_idx,
  output tuner_ctrl_state_e       o_state_mon,
  output logic                    o_locked,
  output logic                    o_err,
  output tuner_ctrl_err_e         o_err_code
);

  localparam int CNT_W   = $clog2(NUM_TARGET + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);

  tuner_ctrl_state_e    r_state;
  tuner_ctrl_err_e      r_err_code;
  logic                 r_srch_trig_val;
  logic                 r_peaks_rdy;
  logic                 r_lock_trig_val;
  logic                 r_intr_rdy;
  logic                 r_resume_val;
  logic                 r_locked;
  logic                 r_err;
  logic [ADC_WIDTH-1:0] r_cfg_pwr;
  logic [DAC_WIDTH-1:0] r_cfg_ring;
  logic [IDX_W-1:0]     r_sel_idx;
  logic [RETRY_W-1:0]   r_retry;
  logic [WD_W-1:0]      r_wdog;
  logic [CNT_W-1:0]     r_cnt_lat;
  logic [ADC_WIDTH-1:0] r_pwr_lat  [NUM_TARGET];
  logic [DAC_WIDTH-1:0] r_ring_lat [NUM_TARGET];

  logic [IDX_W-1:0]     w_sel_idx;

  tuner_ctrl_peak_sel #(
    .ADC_WIDTH  (ADC_WIDTH),
    .NUM_TARGET (NUM_TARGET)
  ) u_peak_sel (
    .i_sel_mode   (i_cfg_sel_mode),
    .i_target_idx (i_cfg_target_idx),
    .i_cnt        (r_cnt_lat),
    .i_pwr        (r_pwr_lat),
    .o_idx        (w_sel_idx)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= IDLE;
      r_err_code      <= NONE;
      r_srch_trig_val <= 1'b0;
      r_peaks_rdy     <= 1'b0;
      r_lock_trig_val <= 1'b0;
      r_intr_rdy      <= 1'b0;
      r_resume_val    <= 1'b0;
      r_locked        <= 1'b0;
      r_err           <= 1'b0;
      r_cfg_pwr       <= '0;
      r_cfg_ring      <= '0;
      r_sel_idx       <= '0;
      r_retry         <= '0;
      r_wdog          <= '0;
      r_cnt_lat       <= '0;
      r_pwr_lat       <= '{default: '0};
      r_ring_lat      <= '{default: '0};
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_srch_trig_val <= 1'b1;
            r_state         <= S_TRIG;
          end
        end

        S_TRIG: begin
          if (search_if.trig_rdy && r_srch_trig_val) begin
            r_srch_trig_val <= 1'b0;
            r_peaks_rdy     <= 1'b1;
            r_wdog          <= '0;
            r_state         <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (search_if.peaks_val && r_peaks_rdy) begin
            r_peaks_rdy <= 1'b0;
            r_pwr_lat   <= search_if.pwr_peaks;
            r_ring_lat  <= search_if.ring_tune_peaks;
            // An over-range count is clamped so the selector never indexes past the slots.
            if (search_if.peaks_cnt > CNT_W'(NUM_TARGET)) begin
              r_cnt_lat <= CNT_W'(NUM_TARGET);
            end else begin
              r_cnt_lat <= search_if.peaks_cnt;
            end
            r_state <= SELECT;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
            if (r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
              r_peaks_rdy <= 1'b0;
              r_err       <= 1'b1;
              r_err_code  <= TIMEOUT;
              r_state     <= ERR;
            end
          end
        end

        SELECT: begin
          if (r_cnt_lat == '0) begin
            r_err      <= 1'b1;
            r_err_code <= NO_PEAK;
            r_state    <= ERR;
          end else begin
            r_sel_idx       <= w_sel_idx;
            r_cfg_pwr       <= r_pwr_lat[w_sel_idx];
            r_cfg_ring      <= r_ring_lat[w_sel_idx];
            r_lock_trig_val <= 1'b1;
            r_state         <= L_TRIG;
          end
        end

        L_TRIG: begin
          if (lock_if.trig_rdy && r_lock_trig_val) begin
            r_lock_trig_val <= 1'b0;
            r_retry         <= '0;
            r_locked        <= 1'b1;
            r_intr_rdy      <= 1'b1;
            r_state         <= LOCKED;
          end
        end

        LOCKED: begin
          if (lock_if.intr_val && r_intr_rdy) begin
            r_locked   <= 1'b0;
            r_intr_rdy <= 1'b0;
            if (r_retry < RETRY_W'(MAX_RETRY)) begin
              r_retry      <= r_retry + RETRY_W'(1);
              r_resume_val <= 1'b1;
              r_state      <= RESUME;
            end else begin
              r_err      <= 1'b1;
              r_err_code <= RETRY;
              r_state    <= ERR;
            end
          end else if (i_stop) begin
            r_locked   <= 1'b0;
            r_intr_rdy <= 1'b0;
            r_state    <= IDLE;
          end
        end

        RESUME: begin
          if (lock_if.resume_rdy && r_resume_val) begin
            r_resume_val <= 1'b0;
            r_locked     <= 1'b1;
            r_intr_rdy   <= 1'b1;
            r_state      <= LOCKED;
          end
        end

        ERR: begin
          if (i_stop) begin
            r_err      <= 1'b0;
            r_err_code <= NONE;
            r_state    <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign search_if.trig_val   = r_srch_trig_val;
  assign search_if.peaks_rdy  = r_peaks_rdy;
  assign lock_if.trig_val     = r_lock_trig_val;
  assign lock_if.intr_rdy     = r_intr_rdy;
  assign lock_if.resume_val   = r_resume_val;

  assign o_cfg_pwr_peak       = r_cfg_pwr;
  assign o_cfg_ring_tune_peak = r_cfg_ring;
  assign o_sel_idx            = r_sel_idx;
  assign o_state_mon          = r_state;
  assign o_locked             = r_locked;
  assign o_err                = r_err;
  assign o_err_code           = r_err_code;

endmodule

// File: tb/tb_tuner_ctrl.sv
// Directed and randomized bench for tuner_ctrl; expected selections come from a simple reference model.
module tb_tuner_ctrl;
  import tuner_phy_pkg::*;

  localparam int NT = 8;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop  = 1'b0;
  logic              mode  = 1'b0;
  logic [2:0]        tidx  = '0;
  logic [7:0]        cfg_pwr;
  logic [7:0]        cfg_ring;
  logic [2:0]        sel_idx;
  tuner_ctrl_state_e st;
  logic              locked;
  logic              err;
  tuner_ctrl_err_e   ecode;

  tuner_search_if #(.DAC_WIDTH(8), .ADC_WIDTH(8), .NUM_TARGET(NT)) s_if ();
  tuner_lock_if l_if ();

  tuner_ctrl #(
    .DAC_WIDTH(8), .ADC_WIDTH(8), .NUM_TARGET(NT), .MAX_RETRY(3), .TIMEOUT_CYCLES(1024)
  ) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_start              (start),
    .i_stop               (stop),
    .i_cfg_sel_mode       (mode),
    .i_cfg_target_idx     (tidx),
    .search_if            (s_if),
    .lock_if              (l_if),
    .o_cfg_pwr_peak       (cfg_pwr),
    .o_cfg_ring_tune_peak (cfg_ring),
    .o_sel_idx            (sel_idx),
    .o_state_mon          (st),
    .o_locked             (locked),
    .o_err                (err),
    .o_err_code           (ecode)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] ref_pwr  [NT];
  logic [7:0] ref_ring [NT];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: mode 0 clamps the index into range; mode 1 finds the peak value, then its first slot.
  function automatic int model_sel(input logic m, input int ix, input int cnt);
    int best;
    if (!m) return (ix < cnt) ? ix : cnt - 1;
    best = 0;
    for (int i = 0; i < cnt; i++) if (int'(ref_pwr[i]) > best) best = int'(ref_pwr[i]);
    for (int i = 0; i < cnt; i++) if (int'(ref_pwr[i]) == best) return i;
    return 0;
  endfunction

  task automatic do_search(input logic m, input logic [2:0] ix, input int cnt, input int dly);
    mode = m;
    tidx = ix;
    for (int i = 0; i < NT; i++) begin
      s_if.pwr_peaks[i]       = ref_pwr[i];
      s_if.ring_tune_peaks[i] = ref_ring[i];
    end
    s_if.peaks_cnt = 4'(cnt);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s_trig_state", 32'(st), 32'(S_TRIG));
    chk("s_trig_val", 32'(s_if.trig_val), 1);
    s_if.trig_rdy = 1'b1;
    tick();
    s_if.trig_rdy = 1'b0;
    chk("s_wait_state", 32'(st), 32'(S_WAIT));
    chk("s_trig_drop", 32'(s_if.trig_val), 0);
    chk("peaks_rdy_set", 32'(s_if.peaks_rdy), 1);
    repeat (dly) tick();
    s_if.peaks_val = 1'b1;
    tick();
    s_if.peaks_val = 1'b0;
    for (int i = 0; i < NT; i++) begin
      s_if.pwr_peaks[i]       = ~ref_pwr[i];
      s_if.ring_tune_peaks[i] = ~ref_ring[i];
    end
    s_if.peaks_cnt = 4'(NT);
    chk("select_state", 32'(st), 32'(SELECT));
    chk("peaks_rdy_drop", 32'(s_if.peaks_rdy), 0);
    tick();
  endtask

  task automatic check_sel(input logic m, input logic [2:0] ix, input int cnt);
    int e;
    e = model_sel(m, int'(ix), cnt);
    chk("l_trig_state", 32'(st), 32'(L_TRIG));
    chk("sel_idx", 32'(sel_idx), 32'(e));
    chk("cfg_pwr", 32'(cfg_pwr), 32'(ref_pwr[e]));
    chk("cfg_ring", 32'(cfg_ring), 32'(ref_ring[e]));
  endtask

  task automatic do_lock(input int nlow);
    int c;
    c = 0;
    for (int k = 0; k < nlow; k++) begin
      if (l_if.trig_val === 1'b1) c++;
      tick();
    end
    if (nlow > 0) chk("l_trig_hold_cycles", 32'(c), 32'(nlow));
    chk("l_trig_val", 32'(l_if.trig_val), 1);
    l_if.trig_rdy = 1'b1;
    tick();
    l_if.trig_rdy = 1'b0;
    chk("locked_state", 32'(st), 32'(LOCKED));
    chk("locked_flag", 32'(locked), 1);
    chk("intr_rdy", 32'(l_if.intr_rdy), 1);
    chk("l_trig_drop", 32'(l_if.trig_val), 0);
  endtask

  task automatic do_intr(input logic with_stop, input logic exp_resume, input int rwait);
    l_if.intr_val = 1'b1;
    stop = with_stop;
    tick();
    l_if.intr_val = 1'b0;
    stop = 1'b0;
    chk("intr_rdy_drop", 32'(l_if.intr_rdy), 0);
    chk("locked_drop", 32'(locked), 0);
    if (exp_resume) begin
      chk("resume_state", 32'(st), 32'(RESUME));
      chk("resume_val", 32'(l_if.resume_val), 1);
      for (int k = 0; k < rwait; k++) begin
        tick();
        chk("resume_hold", 32'(l_if.resume_val), 1);
      end
      l_if.resume_rdy = 1'b1;
      tick();
      l_if.resume_rdy = 1'b0;
      chk("relock_state", 32'(st), 32'(LOCKED));
      chk("resume_drop", 32'(l_if.resume_val), 0);
      chk("relock_flag", 32'(locked), 1);
    end else begin
      chk("retry_err_state", 32'(st), 32'(ERR));
      chk("retry_err_code", 32'(ecode), 32'(RETRY));
      chk("retry_err_flag", 32'(err), 1);
    end
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_idle", 32'(st), 32'(IDLE));
    chk("stop_err_clr", 32'(err), 0);
    chk("stop_code_clr", 32'(ecode), 32'(NONE));
    chk("stop_unlocked", 32'(locked), 0);
  endtask

  task automatic fill_random(input int cnt);
    for (int i = 0; i < NT; i++) begin
      ref_pwr[i]  = (i < cnt) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(200, 255));
      ref_ring[i] = 8'($urandom_range(0, 255));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "global timeout");
  end

  initial begin
    int cnt, n, retries;
    logic m;
    logic [2:0] ix;

    s_if.trig_rdy   = 1'b0;
    s_if.peaks_val  = 1'b0;
    s_if.peaks_cnt  = '0;
    for (int i = 0; i < NT; i++) begin
      s_if.pwr_peaks[i]       = '0;
      s_if.ring_tune_peaks[i] = '0;
    end
    l_if.trig_rdy   = 1'b0;
    l_if.intr_val   = 1'b0;
    l_if.resume_rdy = 1'b0;

    repeat (3) tick();
    chk("rst_state", 32'(st), 32'(IDLE));
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_code", 32'(ecode), 32'(NONE));
    chk("rst_s_trig", 32'(s_if.trig_val), 0);
    chk("rst_peaks_rdy", 32'(s_if.peaks_rdy), 0);
    chk("rst_l_trig", 32'(l_if.trig_val), 0);
    chk("rst_intr_rdy", 32'(l_if.intr_rdy), 0);
    chk("rst_resume", 32'(l_if.resume_val), 0);
    chk("rst_sel_idx", 32'(sel_idx), 0);
    chk("rst_cfg_pwr", 32'(cfg_pwr), 0);
    chk("rst_cfg_ring", 32'(cfg_ring), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(st), 32'(IDLE));

    // Max-power mode with a tie; slots past cnt are louder and must be ignored.
    ref_pwr = '{8'd40, 8'd90, 8'd90, 8'd250, 8'd250, 8'd250, 8'd250, 8'd250};
    for (int i = 0; i < NT; i++) ref_ring[i] = 8'($urandom_range(0, 255));
    do_search(1'b1, 3'd0, 3, 0);
    check_sel(1'b1, 3'd0, 3);
    chk("tie_sel_idx", 32'(sel_idx), 1);
    chk("tie_cfg_pwr", 32'(cfg_pwr), 90);
    do_lock(0);
    do_stop();
    chk("cfg_stable_idle", 32'(cfg_pwr), 90);

    // Index mode clamped to cnt-1; i_stop held high is ignored outside LOCKED/ERR.
    fill_random(4);
    stop = 1'b1;
    do_search(1'b0, 3'd6, 4, 600);
    stop = 1'b0;
    check_sel(1'b0, 3'd6, 4);
    chk("clamp_sel_idx", 32'(sel_idx), 3);
    do_lock(2);
    do_stop();

    for (int it = 0; it < 6; it++) begin
      cnt = int'($urandom_range(1, 8));
      m   = 1'($urandom_range(0, 1));
      ix  = 3'($urandom_range(0, 7));
      fill_random(cnt);
      do_search(m, ix, cnt, int'($urandom_range(0, 4)));
      check_sel(m, ix, cnt);
      do_lock(int'($urandom_range(0, 3)));
      do_stop();
    end

    // Empty peak list.
    fill_random(0);
    do_search(1'b0, 3'd2, 0, 0);
    chk("nopeak_state", 32'(st), 32'(ERR));
    chk("nopeak_code", 32'(ecode), 32'(NO_PEAK));
    chk("nopeak_err", 32'(err), 1);
    chk("nopeak_no_lock_trig", 32'(l_if.trig_val), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_ignores_start", 32'(st), 32'(ERR));
    do_stop();

    // Watchdog: peaks_val never arrives.
    start = 1'b1;
    tick();
    start = 1'b0;
    s_if.trig_rdy = 1'b1;
    tick();
    s_if.trig_rdy = 1'b0;
    n = 0;
    while (st === S_WAIT && n < 1100) begin
      n++;
      tick();
    end
    chk("wdog_wait_cycles", 32'(n), 1024);
    chk("timeout_state", 32'(st), 32'(ERR));
    chk("timeout_code", 32'(ecode), 32'(TIMEOUT));
    chk("timeout_err", 32'(err), 1);
    chk("timeout_rdy_drop", 32'(s_if.peaks_rdy), 0);
    do_stop();

    // Retry budget: three resumes allowed, the fourth interrupt faults.
    fill_random(5);
    do_search(1'b1, 3'd0, 5, 1);
    check_sel(1'b1, 3'd0, 5);
    do_lock(5);
    retries = 0;
    for (int k = 0; k < 4; k++) begin
      do_intr(k == 0, retries < 3, k);
      if (retries < 3) retries++;
    end
    do_stop();

    // Asynchronous reset while a resume handshake is pending.
    fill_random(2);
    do_search(1'b0, 3'd1, 2, 0);
    check_sel(1'b0, 3'd1, 2);
    do_lock(0);
    l_if.intr_val = 1'b1;
    tick();
    l_if.intr_val = 1'b0;
    chk("pre_rst_resume", 32'(l_if.resume_val), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_resume_val", 32'(l_if.resume_val), 0);
    chk("async_rst_state", 32'(st), 32'(IDLE));
    chk("async_rst_intr_rdy", 32'(l_if.intr_rdy), 0);
    chk("async_rst_sel_idx", 32'(sel_idx), 0);
    chk("async_rst_cfg_ring", 32'(cfg_ring), 0);
    tick();
    rst_n = 1'b1;
    l_if.resume_rdy = 1'b1;
    tick();
    l_if.resume_rdy = 1'b0;
    chk("post_rst_no_completion", 32'(st), 32'(IDLE));
    chk("post_rst_unlocked", 32'(locked), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
